// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MULDIV_FAST_MUL_EN to complete multiplies in a single cycle through a combinational product.
module muldiv_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);
    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic [2:0]           op_q;
    logic [W-1:0]         a_mag;
    logic [W-1:0]         b_mag;
    logic                 neg_a;
    logic                 neg_b;
    logic [CNT_WIDTH-1:0] cnt;
    logic [W-1:0]         acc_hi;
    logic [W-1:0]         acc_lo;

    logic         signed_a_in, signed_b_in, in_neg_a, in_neg_b;
    logic [W-1:0] in_mag_a, in_mag_b;
    logic         div_zero, div_ovf, fast_mul;
    logic [W-1:0] special_result, fast_result;

    assign signed_a_in = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    assign signed_b_in = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    assign in_neg_a    = signed_a_in && rs1_i[W-1];
    assign in_neg_b    = signed_b_in && rs2_i[W-1];
    assign in_mag_a    = in_neg_a ? -rs1_i : rs1_i;
    assign in_mag_b    = in_neg_b ? -rs2_i : rs2_i;

    // Divide-by-zero and signed overflow have fixed RISC-V answers, so they bypass iteration.
    assign div_zero = op_i[2] && (rs2_i == '0);
    assign div_ovf  = op_i[2] && !op_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);
    assign special_result = div_zero ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : rs1_i);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] fast_a, fast_b, fast_prod;
    assign fast_a      = {{W{in_neg_a}}, rs1_i};
    assign fast_b      = {{W{in_neg_b}}, rs2_i};
    assign fast_prod   = fast_a * fast_b;
    assign fast_mul    = !op_i[2];
    assign fast_result = (op_i == 3'd0) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
`else
    assign fast_mul    = 1'b0;
    assign fast_result = '0;
`endif

    // One iteration of each algorithm; acc_hi/acc_lo hold {product} or {remainder, quotient}.
    logic [W:0]     mul_sum, div_shift, div_diff;
    logic           div_ok;
    logic [W-1:0]   mul_hi_nxt, mul_lo_nxt, div_rem_nxt, div_quo_nxt;
    logic [2*W-1:0] prod, prod_adj;
    logic [W-1:0]   quo_adj, rem_adj, calc_result;

    assign mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_mag} : '0);
    assign mul_hi_nxt  = mul_sum[W:1];
    assign mul_lo_nxt  = {mul_sum[0], acc_lo[W-1:1]};
    assign div_shift   = {acc_hi, acc_lo[W-1]};
    assign div_diff    = div_shift - {1'b0, b_mag};
    assign div_ok      = !div_diff[W];
    assign div_rem_nxt = div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
    assign div_quo_nxt = {acc_lo[W-2:0], div_ok};

    assign prod     = {mul_hi_nxt, mul_lo_nxt};
    assign prod_adj = (neg_a ^ neg_b) ? -prod : prod;
    assign quo_adj  = (neg_a ^ neg_b) ? -div_quo_nxt : div_quo_nxt;
    assign rem_adj  = neg_a ? -div_rem_nxt : div_rem_nxt;

    always_comb begin
        calc_result = rem_adj;
        case (op_q)
            3'd0:                calc_result = prod_adj[W-1:0];
            3'd1, 3'd2, 3'd3:    calc_result = prod_adj[2*W-1:W];
            3'd4, 3'd5:          calc_result = quo_adj;
            default:             calc_result = rem_adj;
        endcase
    end

    assign busy_o = (state == CALC) || ((state == IDLE) && start_i && !flush_i);

    // Sequencer: the final result is registered on the edge entering DONE so it is valid with done_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else if (flush_i) begin
            state  <= IDLE;
            done_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        op_q   <= op_i;
                        a_mag  <= in_mag_a;
                        b_mag  <= in_mag_b;
                        neg_a  <= in_neg_a;
                        neg_b  <= in_neg_b;
                        cnt    <= CNT_WIDTH'(DATA_WIDTH - 1);
                        acc_hi <= '0;
                        acc_lo <= op_i[2] ? in_mag_a : in_mag_b;
                        if (div_zero || div_ovf) begin
                            state    <= DONE;
                            done_o   <= 1'b1;
                            result_o <= special_result;
                        end else if (fast_mul) begin
                            state    <= DONE;
                            done_o   <= 1'b1;
                            result_o <= fast_result;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_hi <= op_q[2] ? div_rem_nxt : mul_hi_nxt;
                    acc_lo <= op_q[2] ? div_quo_nxt : mul_lo_nxt;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state    <= DONE;
                        done_o   <= 1'b1;
                        result_o <= calc_result;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
